// File: rtl/mac_cam_lut_aging_if.sv
// mac_cam_lut_aging_if
// Lookup/learn bus between the header parser (master) and the MAC CAM (slave).
//   dst_mac, src_mac, src_port, lookup_req, flush : request side, master -> slave
//   dst_ports, lookup_done, lut_hit, lut_miss,
//   num_entries                                   : result side, slave -> master
interface mac_cam_lut_aging_if #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int LUT_DEPTH_BITS    = 4
);
  logic [47:0]                  dst_mac;
  logic [47:0]                  src_mac;
  logic [NUM_OUTPUT_QUEUES-1:0] src_port;
  logic                         lookup_req;
  logic                         flush;
  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports;
  logic                         lookup_done;
  logic                         lut_hit;
  logic                         lut_miss;
  logic [LUT_DEPTH_BITS:0]      num_entries;

  modport master (
    output dst_mac, src_mac, src_port, lookup_req, flush,
    input  dst_ports, lookup_done, lut_hit, lut_miss, num_entries
  );

  modport slave (
    input  dst_mac, src_mac, src_port, lookup_req, flush,
    output dst_ports, lookup_done, lut_hit, lut_miss, num_entries
  );
endinterface

// File: rtl/mac_cam_lut_aging.sv
// mac_cam_lut_aging
// Learning MAC CAM with per-entry valid bits, timed aging, invalid-first
// replacement, multicast handling, flush and an occupancy count.
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : slave side of mac_cam_lut_aging_if (lookup request in,
//            registered dst_ports / lookup_done / lut_hit / lut_miss /
//            num_entries out, one cycle after lookup_req)
module mac_cam_lut_aging #(
  parameter int                         NUM_OUTPUT_QUEUES         = 8,
  parameter int                         LUT_DEPTH_BITS            = 4,
  parameter int                         AGE_BITS                  = 2,
  parameter int                         AGE_TICK_CYCLES           = 1000000,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_MISS_OUTPUT_PORTS = 8'h55
) (
  input  logic                clk,
  input  logic                resetn,
  mac_cam_lut_aging_if.slave  bus
);

  localparam int LUT_DEPTH = 2 ** LUT_DEPTH_BITS;
  localparam int AGE_MAX   = (2 ** AGE_BITS) - 1;
  localparam int TICK_W    = $clog2(AGE_TICK_CYCLES);

  // Table storage
  logic [LUT_DEPTH-1:0]         r_valid;
  logic [47:0]                  r_mac  [LUT_DEPTH];
  logic [NUM_OUTPUT_QUEUES-1:0] r_port [LUT_DEPTH];
  logic [AGE_BITS-1:0]          r_age  [LUT_DEPTH];
  logic [LUT_DEPTH_BITS-1:0]    r_wr_ptr;
  logic [TICK_W-1:0]            r_tick_cnt;

  // Registered outputs
  logic [NUM_OUTPUT_QUEUES-1:0] r_dst_ports;
  logic                         r_lookup_done;
  logic                         r_lut_hit;
  logic                         r_lut_miss;
  logic [LUT_DEPTH_BITS:0]      r_num_entries;

  // Search results against the start-of-cycle table
  logic                         w_dst_hit;
  logic [LUT_DEPTH_BITS-1:0]    w_dst_idx;
  logic                         w_src_hit;
  logic [LUT_DEPTH_BITS-1:0]    w_src_idx;
  logic                         w_any_inv;
  logic [LUT_DEPTH_BITS-1:0]    w_inv_idx;

  logic                         w_tick;
  logic                         w_uni_hit;
  logic                         w_learn;
  logic [LUT_DEPTH_BITS-1:0]    w_learn_idx;
  logic [NUM_OUTPUT_QUEUES-1:0] w_lookup_ports;
  logic [LUT_DEPTH-1:0]         w_valid_nxt;
  logic [LUT_DEPTH_BITS:0]      w_count;

  // Descending scan so the lowest matching / lowest invalid index is the
  // one left standing.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_dst_hit = 1'b0;
    w_dst_idx = '0;
    w_src_hit = 1'b0;
    w_src_idx = '0;
    w_any_inv = 1'b0;
    w_inv_idx = '0;
    for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_mac[i] == bus.dst_mac)) begin
        w_dst_hit = 1'b1;
        w_dst_idx = LUT_DEPTH_BITS'(i);
      end
      if (r_valid[i] && (r_mac[i] == bus.src_mac)) begin
        w_src_hit = 1'b1;
        w_src_idx = LUT_DEPTH_BITS'(i);
      end
      if (!r_valid[i]) begin
        w_any_inv = 1'b1;
        w_inv_idx = LUT_DEPTH_BITS'(i);
      end
    end
  end

  assign w_tick    = (r_tick_cnt == TICK_W'(AGE_TICK_CYCLES - 1));
  // Group bit (bit 40) on the destination forces a flood; on the source it
  // blocks learning.
  assign w_uni_hit = w_dst_hit && !bus.dst_mac[40];
  assign w_learn   = bus.lookup_req && !bus.src_mac[40] && !bus.flush;

  assign w_learn_idx    = w_src_hit ? w_src_idx :
                          w_any_inv ? w_inv_idx : r_wr_ptr;
  assign w_lookup_ports = (w_uni_hit ? r_port[w_dst_idx] : DEFAULT_MISS_OUTPUT_PORTS)
                          & ~bus.src_port;

  // Valid bits after this cycle's flush / learn / expiry. The learned slot
  // is never expired in the same cycle.
  always_comb begin
    w_valid_nxt = r_valid;
    if (bus.flush) begin
      w_valid_nxt = '0;
    end else begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        if (w_learn && (w_learn_idx == LUT_DEPTH_BITS'(i))) begin
          w_valid_nxt[i] = 1'b1;
        end else if (w_tick && r_valid[i] && (r_age[i] == '0)) begin
          w_valid_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      w_count = w_count + {{LUT_DEPTH_BITS{1'b0}}, w_valid_nxt[i]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid       <= '0;
      r_wr_ptr      <= '0;
      r_tick_cnt    <= '0;
      r_dst_ports   <= '0;
      r_lookup_done <= 1'b0;
      r_lut_hit     <= 1'b0;
      r_lut_miss    <= 1'b0;
      r_num_entries <= '0;
    end else begin
      r_valid       <= w_valid_nxt;
      r_num_entries <= w_count;
      r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + 1'b1;

      // Round-robin pointer advances only when a full table is overwritten.
      if (bus.flush) begin
        r_wr_ptr <= '0;
      end else if (w_learn && !w_src_hit && !w_any_inv) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      r_lookup_done <= bus.lookup_req;
      r_lut_hit     <= bus.lookup_req && w_uni_hit;
      r_lut_miss    <= bus.lookup_req && !w_uni_hit;
      if (bus.lookup_req) begin
        r_dst_ports <= w_lookup_ports;
      end
    end
  end

  // NOTE: mac/port/age are deliberately not reset; every read is gated by
  // r_valid, and leaving them out of reset keeps the array as plain storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (w_learn && (w_learn_idx == LUT_DEPTH_BITS'(i))) begin
        r_mac[i]  <= bus.src_mac;
        r_port[i] <= bus.src_port;
        r_age[i]  <= AGE_BITS'(AGE_MAX);
      end else if (w_tick && r_valid[i] && (r_age[i] != '0)) begin
        r_age[i]  <= r_age[i] - 1'b1;
      end
    end
  end

  assign bus.dst_ports   = r_dst_ports;
  assign bus.lookup_done = r_lookup_done;
  assign bus.lut_hit     = r_lut_hit;
  assign bus.lut_miss    = r_lut_miss;
  assign bus.num_entries = r_num_entries;

endmodule

// File: tb/tb_mac_cam_lut_aging.sv
// tb_mac_cam_lut_aging
// Two CAM instances share one stimulus stream: u_dut ticks slowly so table
// contents stay put, u_dut_age ticks every 4 cycles to exercise expiry.
// Each lookup pushes its expected result into a queue; a monitor pops and
// compares when lookup_done appears.
module tb_mac_cam_lut_aging;

  localparam logic [47:0] MC_SRC = 48'h0100_5E00_0001;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mac_cam_lut_aging_if #(.NUM_OUTPUT_QUEUES(8), .LUT_DEPTH_BITS(4)) bus  ();
  mac_cam_lut_aging_if #(.NUM_OUTPUT_QUEUES(8), .LUT_DEPTH_BITS(4)) abus ();

  assign abus.dst_mac    = bus.dst_mac;
  assign abus.src_mac    = bus.src_mac;
  assign abus.src_port   = bus.src_port;
  assign abus.lookup_req = bus.lookup_req;
  assign abus.flush      = bus.flush;

  mac_cam_lut_aging #(.AGE_BITS(2), .AGE_TICK_CYCLES(1000)) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  mac_cam_lut_aging #(.AGE_BITS(2), .AGE_TICK_CYCLES(4)) u_dut_age (
    .clk(clk), .resetn(resetn), .bus(abus)
  );

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [7:0]  port;
    logic        flush;
    logic        hit;
    logic        miss;
    logic [7:0]  ports;
    logic [4:0]  num;
  } vec_t;

  typedef struct {
    vec_t v;
    bit   sel;   // 0: u_dut, 1: u_dut_age
    int   id;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   id_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [47:0] dst, input logic [47:0] src,
                              input logic [7:0] port, input logic flush,
                              input logic hit, input logic [7:0] ports,
                              input logic [4:0] num);
    vec_t v;
    v.dst = dst; v.src = src; v.port = port; v.flush = flush;
    v.hit = hit; v.miss = !hit; v.ports = ports; v.num = num;
    return v;
  endfunction

  task automatic drive_idle();
    bus.lookup_req = 1'b0;
    bus.flush      = 1'b0;
    bus.dst_mac    = '0;
    bus.src_mac    = '0;
    bus.src_port   = '0;
  endtask

  // Called at a negedge; drives one request and returns at the next negedge.
  task automatic send(input vec_t v, input bit sel);
    exp_t e;
    bus.dst_mac    = v.dst;
    bus.src_mac    = v.src;
    bus.src_port   = v.port;
    bus.flush      = v.flush;
    bus.lookup_req = 1'b1;
    e.v = v; e.sel = sel; e.id = id_cnt++;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_idle();
    repeat (n) @(negedge clk);
  endtask

  // Leaves resetn released at a negedge; the next posedge is the first
  // active cycle.
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    drive_idle();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drain(input string name);
    idle(3);
    check({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    check({name, "_done_pulse"}, 64'(bus.lookup_done), 64'd0);
    sb_q.delete();
  endtask

  // Scoreboard monitor: compares away from the active edge.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.lookup_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got lookup_done=1 expected no pending lookup");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.sel) begin
          check($sformatf("lk%0d_hit",   e.id), 64'(abus.lut_hit),     64'(e.v.hit));
          check($sformatf("lk%0d_miss",  e.id), 64'(abus.lut_miss),    64'(e.v.miss));
          check($sformatf("lk%0d_ports", e.id), 64'(abus.dst_ports),   64'(e.v.ports));
          check($sformatf("lk%0d_num",   e.id), 64'(abus.num_entries), 64'(e.v.num));
        end else begin
          check($sformatf("lk%0d_hit",   e.id), 64'(bus.lut_hit),      64'(e.v.hit));
          check($sformatf("lk%0d_miss",  e.id), 64'(bus.lut_miss),     64'(e.v.miss));
          check($sformatf("lk%0d_ports", e.id), 64'(bus.dst_ports),    64'(e.v.ports));
          check($sformatf("lk%0d_num",   e.id), 64'(bus.num_entries),  64'(e.v.num));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl [13];

  initial begin
    // Basic lookup/learn/multicast/flush vectors, applied back to back.
    tbl[0]  = mk(48'h0A, 48'h01,  8'h01, 1'b0, 1'b0, 8'h54, 5'd1);
    tbl[1]  = mk(48'h01, 48'h0A,  8'h04, 1'b0, 1'b1, 8'h01, 5'd2);
    tbl[2]  = mk(48'h0A, 48'h01,  8'h10, 1'b0, 1'b1, 8'h04, 5'd2);  // 01 moves to port 10
    tbl[3]  = mk(48'h01, 48'h0A,  8'h04, 1'b0, 1'b1, 8'h10, 5'd2);
    tbl[4]  = mk(BCAST,  MC_SRC,  8'h10, 1'b0, 1'b0, 8'h45, 5'd2);  // multicast src not learned
    tbl[5]  = mk(48'h0A, MC_SRC,  8'h01, 1'b0, 1'b1, 8'h04, 5'd2);
    tbl[6]  = mk(MC_SRC, 48'h0C,  8'h02, 1'b0, 1'b0, 8'h55, 5'd3);  // multicast dst floods
    tbl[7]  = mk(48'h0C, 48'h0A,  8'h04, 1'b0, 1'b1, 8'h02, 5'd3);
    tbl[8]  = mk(48'h0D, 48'h0D,  8'h08, 1'b0, 1'b0, 8'h55, 5'd4);  // pre-learn table
    tbl[9]  = mk(48'h0D, 48'h0A,  8'h04, 1'b0, 1'b1, 8'h08, 5'd4);
    tbl[10] = mk(48'h0A, 48'h0B,  8'h01, 1'b1, 1'b1, 8'h04, 5'd0);  // flush + hit
    tbl[11] = mk(48'h0A, MC_SRC,  8'h01, 1'b0, 1'b0, 8'h54, 5'd0);
    tbl[12] = mk(48'h0A, 48'h0E,  8'h20, 1'b0, 1'b0, 8'h55, 5'd1);

    // Reset with a request held high: no lookup_done, all outputs clear.
    resetn = 1'b0;
    drive_idle();
    bus.lookup_req = 1'b1;
    bus.dst_mac    = 48'h0A;
    bus.src_mac    = 48'h01;
    bus.src_port   = 8'h01;
    repeat (2) @(negedge clk);
    check("rst_dst_ports",   64'(bus.dst_ports),    64'h0);
    check("rst_lookup_done", 64'(bus.lookup_done),  64'h0);
    check("rst_lut_hit",     64'(bus.lut_hit),      64'h0);
    check("rst_lut_miss",    64'(bus.lut_miss),     64'h0);
    check("rst_num_entries", 64'(bus.num_entries),  64'h0);
    check("rst_num_age",     64'(abus.num_entries), 64'h0);
    drive_idle();

    do_reset();
    for (int i = 0; i < 13; i++) send(tbl[i], 1'b0);
    drain("basic");

    // Fill all 16 entries, then two more overwrite entries 0 and 1.
    do_reset();
    for (int i = 0; i < 16; i++)
      send(mk(BCAST, 48'h100 + 48'(i), 8'h01, 1'b0, 1'b0, 8'h54, 5'(i + 1)), 1'b0);
    send(mk(BCAST, 48'h200, 8'h01, 1'b0, 1'b0, 8'h54, 5'd16), 1'b0);
    send(mk(BCAST, 48'h201, 8'h01, 1'b0, 1'b0, 8'h54, 5'd16), 1'b0);
    send(mk(48'h100, MC_SRC, 8'h02, 1'b0, 1'b0, 8'h55, 5'd16), 1'b0);
    send(mk(48'h101, MC_SRC, 8'h02, 1'b0, 1'b0, 8'h55, 5'd16), 1'b0);
    send(mk(48'h102, MC_SRC, 8'h02, 1'b0, 1'b1, 8'h01, 5'd16), 1'b0);
    send(mk(48'h10F, MC_SRC, 8'h02, 1'b0, 1'b1, 8'h01, 5'd16), 1'b0);
    send(mk(48'h200, MC_SRC, 8'h02, 1'b0, 1'b1, 8'h01, 5'd16), 1'b0);
    send(mk(48'h201, MC_SRC, 8'h02, 1'b0, 1'b1, 8'h01, 5'd16), 1'b0);
    drain("fill");

    // Aging (tick every 4 cycles): learned on cycle 1, ticks on cycles
    // 4/8/12 take age 3->0, the tick on cycle 16 expires it.
    do_reset();
    send(mk(BCAST, 48'h77, 8'h01, 1'b0, 1'b0, 8'h54, 5'd1), 1'b1);
    for (int k = 2; k <= 18; k++) begin
      idle(1);
      check($sformatf("age_num_c%0d", k), 64'(abus.num_entries), (k >= 16) ? 64'd0 : 64'd1);
    end
    drain("age");

    // A lookup on the expiring tick cycle with the same src refreshes it.
    do_reset();
    send(mk(BCAST, 48'h77, 8'h01, 1'b0, 1'b0, 8'h54, 5'd1), 1'b1);
    idle(14);                                                       // cycles 2..15
    send(mk(48'h77, 48'h77, 8'h01, 1'b0, 1'b1, 8'h00, 5'd1), 1'b1); // cycle 16 (tick)
    idle(4);                                                        // cycles 17..20
    check("refresh_num_c20", 64'(abus.num_entries), 64'd1);
    send(mk(48'h77, MC_SRC, 8'h02, 1'b0, 1'b1, 8'h01, 5'd1), 1'b1);
    drain("refresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
